fft_frame_loader: RTL

- Upstream feeder for the 8-point FFT core.
- Accepts a serial stream of complex samples through a valid/ready handshake and packs 8 consecutive samples into parallel lane buses.
- Sequences the core's write/start controls: one write pulse, then start held for the pipeline depth.
- Reports frame completion, then accepts the next frame.

---
 rtl/fft_frame_loader_if.sv | 29 ++
 rtl/fft_frame_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/fft_frame_loader_if.sv
// Sample stream and FFT-core control bundle for the frame loader.
// The slave modport is the loader's view. The master modport is the view of
// whatever drives samples and observes the core controls.
interface fft_frame_loader_if #(
  parameter int DATA_W = 16
);
  // Upstream sample stream
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_real;
  logic [DATA_W-1:0]     s_imag;

  // FFT core side: parallel lanes plus load/compute controls
  logic [8*DATA_W-1:0]   x_real;
  logic [8*DATA_W-1:0]   x_imag;
  logic                  write;
  logic                  start;
  logic                  fft_ready;

  modport master (
    output s_valid, s_real, s_imag, fft_ready,
    input  s_ready, x_real, x_imag, write, start
  );

  modport slave (
    input  s_valid, s_real, s_imag, fft_ready,
    output s_ready, x_real, x_imag, write, start
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Upstream feeder for the 8-point FFT core. It packs 8 streamed complex
// samples into parallel lanes, then sequences the core: one write pulse,
// start held for RUN_CYCLES, and a frame_done pulse. After that it accepts
// the next frame.
module fft_frame_loader #(
  parameter int DATA_W     = 16,
  parameter int RUN_CYCLES = 3    // core pipeline depth, 1..15
) (
  input  logic                 CLK,
  input  logic                 RST,
  fft_frame_loader_if.slave    lb,
  output logic                 frame_done,
  output logic                 busy,
  output logic [7:0]           frame_cnt,
  output logic                 err_ready
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] RUN_LAST = 4'(RUN_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        idx;        // lane that receives the next accepted sample
  logic [3:0]        run_cnt;    // cycles already spent in RUN
  logic              init_q;     // low until the first edge after reset release
  logic              xfer;
  logic              write_q;
  logic              start_q;
  logic [DATA_W-1:0] lane_re [8];
  logic [DATA_W-1:0] lane_im [8];

  // s_ready is the only decoded output. It is held low during reset and in the first cycle after release.
  assign lb.s_ready = init_q && (state == FILL);
  assign xfer       = lb.s_valid && lb.s_ready;
  assign lb.write   = write_q;
  assign lb.start   = start_q;

  // Next-state decode for the frame sequencer
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      FILL:    if (xfer && (idx == 3'd7)) state_nxt = WRITE;
      WRITE:   state_nxt = RUN;
      RUN:     if (run_cnt == RUN_LAST) state_nxt = DONE;
      DONE:    state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State register, lane index and RUN cycle counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state   <= FILL;
      init_q  <= 1'b0;
      idx     <= 3'd0;
      run_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      init_q  <= 1'b1;
      if (xfer) idx <= idx + 3'd1;   // wraps 7 -> 0 at the end of each frame
      run_cnt <= (state == RUN) ? run_cnt + 4'd1 : 4'd0;
    end
  end

  // Registered core controls and status, decoded from the state being entered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_q    <= 1'b0;
      start_q    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
      err_ready  <= 1'b0;
    end else begin
      write_q    <= (state_nxt == WRITE);
      start_q    <= (state_nxt == RUN);
      frame_done <= (state_nxt == DONE);
      busy       <= (state_nxt != FILL);
      if (state_nxt == DONE) frame_cnt <= frame_cnt + 8'd1;
      if ((state == RUN) && (run_cnt == RUN_LAST) && !lb.fft_ready) err_ready <= 1'b1;
    end
  end

  // Lane storage. Only an accepted sample writes, so junk on an idle bus never reaches the lanes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the lanes are reset because the core sees them directly and they must read 0 after reset.
      for (int k = 0; k < 8; k++) begin
        lane_re[k] <= '0;
        lane_im[k] <= '0;
      end
    end else if (xfer) begin
      lane_re[idx] <= lb.s_real;
      lane_im[idx] <= lb.s_imag;
    end
  end

  // Flatten the lanes onto the packed buses; lane k sits at [k*DATA_W +: DATA_W]
  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign lb.x_real[k*DATA_W +: DATA_W] = lane_re[k];
    assign lb.x_imag[k*DATA_W +: DATA_W] = lane_im[k];
  end

endmodule
